// File: rtl/encoder_pkg.sv
//------------------------------------------------------------------------------
// Module   : encoder_pkg
// Brief    : Shared widths and types for the 8-to-3 priority encoder.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package encoder_pkg;

    localparam int ENC_IN_W  = 8;
    localparam int ENC_OUT_W = $clog2(ENC_IN_W);

    typedef logic [ENC_IN_W-1:0]  enc_in_t;
    typedef logic [ENC_OUT_W-1:0] enc_idx_t;

endpackage : encoder_pkg

`default_nettype wire

// File: rtl/prio_enc_comb.sv
//------------------------------------------------------------------------------
// Module   : prio_enc_comb
// Brief    : Combinational highest-set-bit priority encoder with any/multi flags.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module prio_enc_comb #(
    parameter  int IN_W  = 8,
    localparam int OUT_W = $clog2(IN_W)
) (
    input  logic [IN_W-1:0]  in,
    output logic [OUT_W-1:0] idx,
    output logic             any,
    output logic             multi
);

    logic [OUT_W-1:0] w_idx;
    logic [IN_W-1:0]  w_low_cleared;

    // Ascending scan: the last set bit visited is the most significant one.
    always_comb begin
        w_idx = '0;
        for (int i = 0; i < IN_W; i++) begin
            if (in[i]) begin
                w_idx = OUT_W'(i);
            end
        end
    end

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign w_low_cleared = in & (in - IN_W'(1));

    assign idx   = w_idx;
    assign any   = |in;
    assign multi = |w_low_cleared;

endmodule : prio_enc_comb

`default_nettype wire

// File: rtl/encoder_8to3.sv
//------------------------------------------------------------------------------
// Module   : encoder_8to3
// Brief    : Registered priority encoder; ENC_MULTIHOT_ERR_EN adds the err flag.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module encoder_8to3
    import encoder_pkg::*;
#(
    parameter  int IN_W  = ENC_IN_W,
    localparam int OUT_W = $clog2(IN_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [IN_W-1:0]  in,
    output logic [OUT_W-1:0] out,
    output logic             valid
`ifdef ENC_MULTIHOT_ERR_EN
    ,
    output logic             err
`endif
);

    logic [OUT_W-1:0] w_idx;
    logic             w_any;
    logic             w_multi;

    logic [OUT_W-1:0] r_out;
    logic             r_valid;

    prio_enc_comb #(
        .IN_W  (IN_W)
    ) u_prio_enc_comb (
        .in    (in),
        .idx   (w_idx),
        .any   (w_any),
        .multi (w_multi)
    );

    // Reset outranks enable; with en low the captured result is held.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out   <= '0;
            r_valid <= 1'b0;
        end else if (en) begin
            r_out   <= w_idx;
            r_valid <= w_any;
        end
    end

    assign out   = r_out;
    assign valid = r_valid;

`ifdef ENC_MULTIHOT_ERR_EN
    logic r_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (en) begin
            r_err <= w_multi;
        end
    end

    assign err = r_err;
`else
    logic w_unused_multi;
    assign w_unused_multi = w_multi;
`endif

endmodule : encoder_8to3

`default_nettype wire

// File: tb/tb_encoder_8to3.sv
//------------------------------------------------------------------------------
// Module   : tb_encoder_8to3
// Brief    : Scoreboard bench for encoder_8to3 with a behavioural reference model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_encoder_8to3;

    typedef struct {
        logic [2:0] out;
        logic       valid;
        logic       err;
        string      tag;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] in;
    logic [2:0] out;
    logic       valid;
`ifdef ENC_MULTIHOT_ERR_EN
    logic       err;
`endif

    exp_t       sb_q[$];
    int         tests_run;
    int         tests_failed;

    // Reference model state: what the registers should hold.
    logic [2:0] m_out;
    logic       m_valid;
    logic       m_err;

    encoder_8to3 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .in    (in),
        .out   (out),
        .valid (valid)
`ifdef ENC_MULTIHOT_ERR_EN
        ,
        .err   (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // floor(log2(v)) for non-zero v, 0 for zero.
    function automatic logic [2:0] ref_msb(input logic [7:0] v);
        int n;
        int idx;
        n   = int'(v);
        idx = 0;
        while (n > 1) begin
            n   = n / 2;
            idx = idx + 1;
        end
        return 3'(idx);
    endfunction

    // Drive one cycle of stimulus, advance the model, and queue the expectation.
    task automatic apply(input logic r, input logic e, input logic [7:0] v, input string tag);
        exp_t x;
        @(negedge clk);
        rst_n = r;
        en    = e;
        in    = v;
        if (!r) begin
            m_out   = 3'd0;
            m_valid = 1'b0;
            m_err   = 1'b0;
        end else if (e) begin
            m_out   = ref_msb(v);
            m_valid = (v != 8'd0);
            m_err   = ($countones(v) >= 2);
        end
        x.out   = m_out;
        x.valid = m_valid;
        x.err   = m_err;
        x.tag   = tag;
        sb_q.push_back(x);
    endtask

    // Monitor: one registered result per edge, checked just after it settles.
    always @(posedge clk) begin
        exp_t x;
        logic bad;
        #1;
        if (sb_q.size() > 0) begin
            x   = sb_q.pop_front();
            bad = (out !== x.out) || (valid !== x.valid);
`ifdef ENC_MULTIHOT_ERR_EN
            bad = bad || (err !== x.err);
            if (bad)
                $display("FAIL %s: got out=%0d valid=%0b err=%0b, expected out=%0d valid=%0b err=%0b",
                         x.tag, out, valid, err, x.out, x.valid, x.err);
`else
            if (bad)
                $display("FAIL %s: got out=%0d valid=%0b, expected out=%0d valid=%0b",
                         x.tag, out, valid, x.out, x.valid);
`endif
            tests_run = tests_run + 1;
            if (bad) tests_failed = tests_failed + 1;
        end
    end

    initial begin
        logic [7:0] v;
        logic       r;
        logic       e;
        int         wait_cycles;

        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        en           = 1'b1;
        in           = 8'hFF;
        m_out        = 3'd0;
        m_valid      = 1'b0;
        m_err        = 1'b0;

        // Reset with all requests active, then release.
        apply(1'b0, 1'b1, 8'hFF, "reset0");
        apply(1'b0, 1'b1, 8'hFF, "reset1");
        apply(1'b1, 1'b1, 8'hFF, "post_reset_ff");

        // One-hot walk.
        for (int k = 0; k < 8; k++) begin
            v = 8'd1 << k;
            apply(1'b1, 1'b1, v, $sformatf("onehot_%0d", k));
        end

        // Zero input, then bit 0 alone.
        apply(1'b1, 1'b1, 8'h00, "zero");
        apply(1'b1, 1'b1, 8'h01, "bit0_only");

        // Multi-hot priority.
        apply(1'b1, 1'b1, 8'b1010_1110, "multi_ae");
        apply(1'b1, 1'b1, 8'b0000_0110, "multi_06");

        // Enable hold.
        apply(1'b1, 1'b1, 8'h20, "load_20");
        for (int k = 0; k < 3; k++)
            apply(1'b1, 1'b0, 8'h02, $sformatf("hold_%0d", k));
        apply(1'b1, 1'b1, 8'h02, "en_resume");

        // Mid-operation reset.
        apply(1'b1, 1'b1, 8'h80, "pre_rst_80");
        apply(1'b0, 1'b1, 8'h80, "mid_rst");
        apply(1'b1, 1'b1, 8'h80, "post_mid_rst");

        // Randomized traffic: mix of zero, one-hot and arbitrary vectors.
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 3))
                0:       v = 8'h00;
                1:       v = 8'd1 << $urandom_range(0, 7);
                default: v = 8'($urandom);
            endcase
            r = ($urandom_range(0, 19) != 0);
            e = ($urandom_range(0, 3) != 0);
            apply(r, e, v, $sformatf("rand_%0d", n));
        end

        // Drain the scoreboard with a bounded wait.
        wait_cycles = 0;
        while (sb_q.size() > 0 && wait_cycles < 20) begin
            @(posedge clk);
            wait_cycles = wait_cycles + 1;
        end
        @(negedge clk);
        if (sb_q.size() > 0) begin
            $display("FAIL drain: got %0d pending, expected 0 pending", sb_q.size());
            tests_run    = tests_run + 1;
            tests_failed = tests_failed + 1;
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_encoder_8to3

`default_nettype wire

// File: doc/encoder_8to3.md
Name: encoder_8to3

Overview:
- Registered 8-to-3 priority encoder that converts an 8-bit one-hot request vector into a 3-bit binary index.
- A valid flag marks a non-zero input, and an optional error flag marks inputs with more than one bit set.
- Used wherever a one-hot select or request vector must be compressed to an index before use in a register or mux stage.

Parameters:
- IN_W, 8, input vector width; must be a power of two and at least 2.
- OUT_W, $clog2(IN_W) = 3, output index width. This is a localparam derived from IN_W and is not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- en  input  1  capture enable; when low, registered outputs hold their value
- in  input  IN_W  request vector; bit i set means index i is requested
- out  output  OUT_W  encoded index, registered
- valid  output  1  registered; high when the captured input was non-zero
- err  output  1  registered; high when the captured input had two or more bits set (present only with ENC_MULTIHOT_ERR_EN)

Behaviour:
- Single clock domain, with all outputs driven directly from flops.
- Reset is synchronous and active-low:
  - Sampled on the rising edge of clk while rst_n = 0.
  - Sets out = 0, valid = 0, err = 0.
  - Reset has priority over en.
- Latency is 1 cycle. The outputs sampled at edge N reflect the value of in present at edge N, provided en = 1 at edge N.
- en = 0: out, valid and err hold their previous values, and in is ignored.
- Encoding is by priority, with the highest-index set bit winning. out = index of the most-significant 1 in in.
- One-hot input 2^k: out = k, valid = 1, err = 0.
- Zero input: out = 0, valid = 0, err = 0. The value out = 0 is only meaningful when valid = 1.
- Multi-hot input:
  - out = index of the highest set bit, valid = 1, err = 1.
  - Example: 8'b1010_1110 gives out = 3'b111.
- Bit 0 alone: out = 0, valid = 1. This case is distinguishable from zero input only through valid.
- No X propagation: an X or Z on in must not reach the flops after reset. Verification treats X on in as illegal stimulus.
- Fully synthesizable; no latches.

Optional Feature:
- Macro: ENC_MULTIHOT_ERR_EN.
- Defined:
  - err port exists.
  - err is registered with the same timing, enable and reset rules as valid.
  - err = 1 when popcount(in) >= 2.
- Undefined:
  - err port and its logic are absent.
  - Multi-hot inputs still encode by highest-set-bit priority with valid = 1.
  - out and valid behaviour is identical in both builds.

Decomposition:
- Package encoder_pkg:
  - localparam ENC_IN_W = 8
  - localparam ENC_OUT_W = 3
  - typedef enc_in_t (logic [ENC_IN_W-1:0])
  - typedef enc_idx_t (logic [ENC_OUT_W-1:0])
- One combinational sub-module, prio_enc_comb:
  - Inputs: in. Outputs: idx, any, multi.
  - Parameterized by IN_W and purely combinational.
- encoder_8to3 wraps prio_enc_comb with the enable/reset register stage and the optional err logic.

Test Plan:
- Reset: rst_n = 0 for 2 cycles with in = 8'hFF and en = 1 -> out = 0, valid = 0, err = 0. Release reset and hold in = 8'hFF -> next cycle out = 3'b111, valid = 1, err = 1.
- One-hot walk: en = 1, in = 8'h01, 02, 04, 08, 10, 20, 40, 80 on consecutive cycles -> one cycle later out = 0, 1, 2, 3, 4, 5, 6, 7, each with valid = 1, err = 0.
- Zero input: in = 8'h00 -> out = 0, valid = 0, err = 0. Then in = 8'h01 -> out = 0, valid = 1.
- Multi-hot priority: in = 8'b1010_1110 -> out = 3'b111, valid = 1, err = 1. in = 8'b0000_0110 -> out = 3'b010, err = 1.
- Enable hold: load in = 8'h20 (out = 5). Drop en and drive in = 8'h02 for 3 cycles -> out stays 5, valid stays 1. Raise en -> out = 1 one cycle later.
- Mid-operation reset: while out = 7 and en = 1, assert rst_n = 0 for 1 cycle -> outputs are 0 at that edge. Deassert rst_n -> normal capture resumes on the next edge.
